// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request channels from the datapath plus the shared RAM port.
// The slave modport is the arbiter's view; master is the requester/RAM side.
`default_nettype none

interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        merr;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [1:0]  ramstate;
    logic [31:0] ramload;
    logic [1:0]  gnt;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output ihit, iload, dhit, dload, merr, ramREN, ramWEN, ramaddr, ramstore, gnt
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  ihit, iload, dhit, dload, merr, ramREN, ramWEN, ramaddr, ramstore, gnt
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one shared RAM port to instruction fetch or data access,
// data first with a starvation bound on fetches, and a per-access timeout.
`default_nettype none

module mem_arbiter #(
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  wire           CLK,
    input  wire           nRST,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_data_q, req_data_d;

    logic in_grant;
    logic owner_req;
    logic done;
    logic fin;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            wait_q     <= 8'd0;
            starve_q   <= 4'd0;
            req_addr_q <= 32'd0;
            req_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            starve_q   <= starve_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        starve_d     = starve_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        bus.ihit     = 1'b0;
        bus.dhit     = 1'b0;
        bus.merr     = 1'b0;
        bus.iload    = 32'd0;
        bus.dload    = 32'd0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'd0;
        bus.ramstore = 32'd0;
        bus.gnt      = state_q;
        owner_req    = 1'b0;

        in_grant = (state_q != IDLE);
        done     = (bus.ramstate == RAM_ACCESS);

        case (state_q)
            IFETCH:  owner_req = bus.iREN;
            DREAD:   owner_req = bus.dREN;
            DWRITE:  owner_req = bus.dWEN;
            default: owner_req = 1'b0;
        endcase

        // Completion, error and timeout all end the grant; they beat withdrawal.
        fin = in_grant && (done || (bus.ramstate == RAM_ERROR) || (wait_q == TMO_LAST));

        if (in_grant) begin
            bus.ramREN  = (state_q == IFETCH) || (state_q == DREAD);
            bus.ramWEN  = (state_q == DWRITE);
            bus.ramaddr = req_addr_q;
            if (state_q == DWRITE) begin
                bus.ramstore = req_data_q;
            end
        end

        if (fin) begin
            bus.ihit = (state_q == IFETCH);
            bus.dhit = (state_q != IFETCH);
            bus.merr = !done;
            if (done && state_q == IFETCH) begin
                bus.iload = bus.ramload;
            end
            if (done && state_q == DREAD) begin
                bus.dload = bus.ramload;
            end
        end

        if (!bus.iREN) begin
            starve_d = 4'd0;
        end else if (fin && state_q == IFETCH) begin
            starve_d = 4'd0;
        end else if (fin && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end

        // Arbitrate on the updated starve count so the limit-th data hit hands over.
        if (!in_grant || fin) begin
            wait_d = 8'd0;
            if (starve_d == STARVE_MAX && bus.iREN) begin
                state_d    = IFETCH;
                req_addr_d = bus.iaddr;
                req_data_d = 32'd0;
            end else if (bus.dWEN) begin
                state_d    = DWRITE;
                req_addr_d = bus.daddr;
                req_data_d = bus.dstore;
            end else if (bus.dREN) begin
                state_d    = DREAD;
                req_addr_d = bus.daddr;
                req_data_d = 32'd0;
            end else if (bus.iREN) begin
                state_d    = IFETCH;
                req_addr_d = bus.iaddr;
                req_data_d = 32'd0;
            end else begin
                state_d    = IDLE;
            end
        end else if (!owner_req) begin
            state_d = IDLE;
            wait_d  = 8'd0;
        end else begin
            wait_d  = wait_q + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven cycle vectors plus hand sequences for
// starvation, timeout and asynchronous reset of mem_arbiter.
`default_nettype none

module tb_mem_arbiter;

    localparam logic [1:0] F = 2'd0;
    localparam logic [1:0] B = 2'd1;
    localparam logic [1:0] A = 2'd2;
    localparam logic [1:0] E = 2'd3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(15), .STARVE_LIMIT(4)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0]  req;    // {iREN, dREN, dWEN}
        logic [1:0]  rs;
        logic [31:0] rl;
        logic [4:0]  flags;  // {ihit, dhit, merr, ramREN, ramWEN}
        logic [1:0]  g;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] il;
        logic [31:0] dl;
    } vec_t;

    vec_t vecs[24];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [134:0] outs();
        return {bus.ihit, bus.dhit, bus.merr, bus.ramREN, bus.ramWEN, bus.gnt,
                bus.ramaddr, bus.ramstore, bus.iload, bus.dload};
    endfunction

    task automatic chk(input string name, input logic [134:0] act, input logic [134:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [1:0] rs, input logic [31:0] rl);
        bus.iREN     = req[2];
        bus.dREN     = req[1];
        bus.dWEN     = req[0];
        bus.ramstate = rs;
        bus.ramload  = rl;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.iaddr  = 32'h0000_0100;
        bus.daddr  = 32'h0000_0200;
        bus.dstore = 32'hDEAD_BEEF;
        drive(3'b000, A, 32'h1234_5678);

        vecs[0]  = '{3'b000, F, 32'h0,        5'b00000, 2'd0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[1]  = '{3'b100, B, 32'h0,        5'b00000, 2'd0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[2]  = '{3'b100, B, 32'h0,        5'b00010, 2'd1, 32'h100, 32'h0,        32'h0,        32'h0};
        vecs[3]  = '{3'b100, B, 32'h0,        5'b00010, 2'd1, 32'h100, 32'h0,        32'h0,        32'h0};
        vecs[4]  = '{3'b100, A, 32'h8C220004, 5'b10010, 2'd1, 32'h100, 32'h0,        32'h8C220004, 32'h0};
        vecs[5]  = '{3'b000, F, 32'h0,        5'b00010, 2'd1, 32'h100, 32'h0,        32'h0,        32'h0};
        vecs[6]  = '{3'b000, F, 32'h0,        5'b00000, 2'd0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[7]  = '{3'b101, F, 32'h0,        5'b00000, 2'd0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[8]  = '{3'b101, B, 32'h0,        5'b00001, 2'd3, 32'h200, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[9]  = '{3'b100, A, 32'h12345678, 5'b01001, 2'd3, 32'h200, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[10] = '{3'b000, A, 32'h11112222, 5'b10010, 2'd1, 32'h100, 32'h0,        32'h11112222, 32'h0};
        vecs[11] = '{3'b000, F, 32'h0,        5'b00000, 2'd0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[12] = '{3'b100, F, 32'h0,        5'b00000, 2'd0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[13] = '{3'b000, E, 32'h55,       5'b10110, 2'd1, 32'h100, 32'h0,        32'h0,        32'h0};
        vecs[14] = '{3'b001, F, 32'h0,        5'b00000, 2'd0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[15] = '{3'b000, E, 32'h55,       5'b01101, 2'd3, 32'h200, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[16] = '{3'b000, F, 32'h0,        5'b00000, 2'd0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[17] = '{3'b010, F, 32'h0,        5'b00000, 2'd0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[18] = '{3'b010, B, 32'h0,        5'b00010, 2'd2, 32'h200, 32'h0,        32'h0,        32'h0};
        vecs[19] = '{3'b000, B, 32'h0,        5'b00010, 2'd2, 32'h200, 32'h0,        32'h0,        32'h0};
        vecs[20] = '{3'b000, A, 32'h77,       5'b00000, 2'd0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[21] = '{3'b010, F, 32'h0,        5'b00000, 2'd0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[22] = '{3'b000, A, 32'hCAFEF00D, 5'b01010, 2'd2, 32'h200, 32'h0,        32'h0,        32'hCAFEF00D};
        vecs[23] = '{3'b000, F, 32'h0,        5'b00000, 2'd0, 32'h0,   32'h0,        32'h0,        32'h0};

        // Reset with live-looking inputs must still hold every output at zero.
        @(negedge clk);
        #2 chk("reset", outs(), 135'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].rs, vecs[i].rl);
            #2 chk($sformatf("row%0d", i), outs(),
                   {vecs[i].flags, vecs[i].g, vecs[i].addr, vecs[i].store, vecs[i].il, vecs[i].dl});
        end

        // Starvation: both channels held, every grant cycle ACCESS.
        begin
            int  nd;
            bit  got_i;
            bit  both;
            logic [31:0] il_seen;
            nd = 0; got_i = 0; both = 0; il_seen = 32'd0;
            for (int c = 0; c < 40 && !got_i; c++) begin
                @(negedge clk);
                drive(3'b110, A, 32'hA5A5_A5A5);
                #2;
                if (bus.ihit && bus.dhit) both = 1;
                if (bus.dhit) nd++;
                if (bus.ihit) begin
                    got_i   = 1;
                    il_seen = bus.iload;
                end
            end
            checks++;
            if (nd != 4) begin
                errors++;
                $display("FAIL starve_dhits act=%0d req=4", nd);
            end
            checks++;
            if (!got_i || il_seen !== 32'hA5A5_A5A5) begin
                errors++;
                $display("FAIL starve_ihit act=%0d/%h req=1/a5a5a5a5", got_i, il_seen);
            end
            checks++;
            if (both) begin
                errors++;
                $display("FAIL hits_exclusive act=1 req=0");
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(3'b000, F, 32'h0);
        end
        #2 chk("starve_idle", outs(), 135'd0);

        // Timeout: RAM stays BUSY for the whole DREAD grant.
        @(negedge clk);
        drive(3'b010, B, 32'h9999_9999);
        #2 chk("tmo_idle", outs(), 135'd0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            drive((k < 15) ? 3'b010 : 3'b000, B, 32'h9999_9999);
            #2 chk($sformatf("tmo_cyc%0d", k), outs(),
                   {(k == 15) ? 5'b01110 : 5'b00010, 2'd2, 32'h200, 32'h0, 32'h0, 32'h0});
        end
        @(negedge clk);
        drive(3'b000, F, 32'h0);
        #2 chk("tmo_after", outs(), 135'd0);

        // Asynchronous reset in the middle of a write grant.
        @(negedge clk);
        drive(3'b001, F, 32'h0);
        @(negedge clk);
        drive(3'b001, B, 32'h0);
        #2 chk("rst_pre", outs(), {5'b00001, 2'd3, 32'h200, 32'hDEADBEEF, 32'h0, 32'h0});
        #1 rst_n = 1'b0;
        #1 chk("rst_async", outs(), 135'd0);
        @(negedge clk);
        drive(3'b000, F, 32'h0);
        rst_n = 1'b1;
        #2 chk("rst_release", outs(), 135'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the CPU datapath's instruction-fetch and data-access request channels and one shared RAM port. Grants the RAM to one requester at a time: data has priority, and a starvation counter bounds how long a fetch can wait. It sequences each access over the RAM's busy/access handshake, enforces a timeout, and returns per-channel hit, load data and error. It sits between the datapath's cache-side request signals and the RAM.

## Interface
- TIMEOUT, 15: consecutive non-ACCESS cycles in a grant state before the access is aborted with error (1..255).
- STARVE_LIMIT, 4: consecutive data grants that may complete while a fetch is pending before the fetch wins (1..15).
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  instruction read request; held until ihit.
- iaddr  in  32  instruction word address.
- dREN  in  1  data read request; held until dhit.
- dWEN  in  1  data write request; held until dhit. dREN&dWEN together is illegal (treated as write).
- daddr  in  32  data address.
- dstore  in  32  data write value.
- ihit  out  1  one-cycle pulse: fetch complete, iload valid this cycle.
- iload  out  32  fetched word (equals ramload while ihit, else 0).
- dhit  out  1  one-cycle pulse: data access complete.
- dload  out  32  read data (equals ramload while dhit on a read, else 0).
- merr  out  1  one-cycle pulse with ihit/dhit when the access ended in ERROR or timeout.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- gnt  out  2  current owner: 0 none, 1 instruction, 2 data read, 3 data write.

## Operation
- States: IDLE, IFETCH, DREAD, DWRITE. Reset puts the FSM in IDLE, zeroes the counters and address/data latches, and drives every output to 0.
- Arbitration runs in IDLE and in the completion cycle of any grant:
  - If starve_cnt == STARVE_LIMIT and iREN, grant IFETCH.
  - Otherwise dWEN grants DWRITE, then dREN grants DREAD, then iREN grants IFETCH. If none is set, go to IDLE.
- On a grant, latch address (and dstore for writes) into req_addr/req_data. RAM outputs are driven from the latches only; requester changes mid-grant are ignored.
- In a grant state, ramREN (IFETCH/DREAD) or ramWEN (DWRITE) is held at 1 and ramaddr/ramstore come from the latches. In IDLE all RAM outputs are 0.
- Completion is ramstate==ACCESS in a grant state. That cycle pulses the owner's hit and drives load combinationally from ramload.
- ramstate==ERROR in a grant state pulses the owner's hit and merr together. Load is 0.
- Timeout: wait_cnt (8 bit) increments each grant cycle without ACCESS/ERROR and clears on a new grant. When wait_cnt reaches TIMEOUT-1 and the cycle is still not ACCESS/ERROR, pulse hit+merr and leave the state.
- Withdrawal: if the owner drops its request (iREN, or dREN/dWEN as appropriate) before completion, abort without a hit. The FSM re-arbitrates next cycle from IDLE.
- starve_cnt (4 bit):
  - +1 when a data grant completes while iREN is high.
  - Cleared when an IFETCH completes or when iREN is low.
  - Saturates at STARVE_LIMIT.
- gnt reflects the registered state.

## Timing
- Request seen in IDLE at cycle N: grant registered at edge N+1, RAM enables asserted in cycle N+1.
- If ramstate==ACCESS in N+1, hit occurs in N+1 (minimum latency 1 cycle).
- Back-to-back: a completion cycle selects the next grant directly. The next access drives the RAM the following cycle with no IDLE bubble.
- A requester must drop its request in the cycle after its hit. If it is still high at re-arbitration, that counts as a new request (the arbiter cannot distinguish).
- The hit pulse is exactly one cycle. ihit and dhit are never high together.
- Asynchronous reset mid-access: outputs go to 0 immediately, and the RAM enables drop without waiting for ACCESS.

## Test plan
- Reset, then iREN=1, iaddr=0x100, ramstate ACCESS on the 3rd grant cycle -> ramREN=1, ramaddr=0x100 from cycle 1; ihit pulses in cycle 3 with iload=ramload (0x8C220004); gnt 1→0 when iREN drops.
- iREN and dWEN asserted together, daddr=0x200, dstore=0xDEADBEEF -> DWRITE first (ramWEN=1, ramstore=0xDEADBEEF); dhit, then IFETCH granted the next cycle with no IDLE.
- Starvation: iREN held, dREN re-asserted after each hit with ACCESS every grant cycle -> exactly 4 dhits, then an IFETCH grant despite dREN=1.
- ramstate held BUSY for 15 grant cycles in DREAD -> dhit and merr pulse in the 15th cycle, dload=0, then return to IDLE.
- ramstate=ERROR in IFETCH -> ihit+merr in the same cycle, iload=0; ramstate=ERROR during DWRITE behaves the same on dhit.
- dREN dropped in grant cycle 2 of DREAD -> no dhit, IDLE next cycle, RAM enables 0; nRST pulled low mid-DWRITE -> ramWEN=0 immediately and gnt=0.
